// File: rtl/usb_pkg.sv
// Shared encodings for the FX2 slave-FIFO arbiter: states, endpoint addresses,
// strobe levels and grant codes.
package usb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RX_SETUP = 3'd1,
    ST_RX_BURST = 3'd2,
    ST_TX_SETUP = 3'd3,
    ST_TX_BURST = 3'd4,
    ST_TX_PKEND = 3'd5,
    ST_TURN     = 3'd6
  } state_e;

  localparam logic [1:0] EP2_ADDR   = 2'b00;
  localparam logic [1:0] EP6_ADDR   = 2'b10;

  localparam logic       STROBE_ON  = 1'b0;
  localparam logic       STROBE_OFF = 1'b1;

  localparam logic [1:0] GNT_NONE   = 2'b00;
  localparam logic [1:0] GNT_RX     = 2'b01;
  localparam logic [1:0] GNT_TX     = 2'b10;

  function automatic logic [1:0] grant_of(input state_e s);
    case (s)
      ST_RX_SETUP, ST_RX_BURST:             return GNT_RX;
      ST_TX_SETUP, ST_TX_BURST, ST_TX_PKEND: return GNT_TX;
      default:                              return GNT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/usb_rr_arbiter.sv
// Two-requester round-robin; grant is combinational from req, last winner is registered.
// Latency 0 for grant, 1 cycle for the fairness update; no backpressure (advance gates the update).
module usb_rr_arbiter
  import usb_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  output logic [1:0] grant_o
);

  logic [1:0] last_q, last_d;

  always_comb begin
    grant_o = GNT_NONE;
    case (req_i)
      2'b01:   grant_o = GNT_RX;
      2'b10:   grant_o = GNT_TX;
      2'b11:   grant_o = (last_q == GNT_TX) ? GNT_RX : GNT_TX;
      default: grant_o = GNT_NONE;
    endcase
    last_d = last_q;
    if (advance_i && (grant_o != GNT_NONE)) last_d = grant_o;
  end

  // Reset to TX so that RX wins the first tie.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) last_q <= GNT_TX;
    else         last_q <= last_d;
  end

endmodule

// File: rtl/usb_fifo_arbiter.sv
// Time-shares the FX2 slave-FIFO pins between the EP2 RX stream and the EP6 TX stream.
// Latency: 1 setup cycle per grant, combinational strobes in bursts; backpressure via flaga/flagd and i_rx_ready.
module usb_fifo_arbiter
  import usb_pkg::*;
#(
  parameter int         DATA_WIDTH      = 16,
  parameter int         MAX_BURST       = 256,
  parameter int         TURNAROUND      = 2,
  parameter int         TX_IDLE_TIMEOUT = 16,
  parameter logic [1:0] EP_OUT_ADDR     = EP2_ADDR,
  parameter logic [1:0] EP_IN_ADDR      = EP6_ADDR
) (
  input  logic                  i_usb_ifclk,
  input  logic                  i_rst_n,
  input  logic                  i_usb_flaga,
  input  logic                  i_usb_flagd,
  inout  wire  [DATA_WIDTH-1:0] io_usb_data,
  output logic [1:0]            o_usb_addr,
  output logic                  o_usb_slrd,
  output logic                  o_usb_slwr,
  output logic                  o_usb_sloe,
  output logic                  o_usb_pkend,
  output logic [DATA_WIDTH-1:0] o_rx_data,
  output logic                  o_rx_valid,
  input  logic                  i_rx_ready,
  input  logic [DATA_WIDTH-1:0] i_tx_data,
  input  logic                  i_tx_valid,
  input  logic                  i_tx_last,
  output logic                  o_tx_ready,
  output logic [1:0]            o_grant,
  output logic                  o_busy
);

  localparam int             CW        = $clog2(MAX_BURST + 1);
  localparam int             IW        = $clog2(TX_IDLE_TIMEOUT + 1);
  localparam logic [CW-1:0]  CNT_MAX   = CW'(MAX_BURST);
  localparam logic [CW-1:0]  CNT_LAST  = CW'(MAX_BURST - 1);
  localparam logic [IW-1:0]  IDLE_LAST = IW'(TX_IDLE_TIMEOUT - 1);
  localparam logic [2:0]     TURN_LAST = 3'(TURNAROUND - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idle_q, idle_d;
  logic [2:0]    turn_q, turn_d;
  logic [1:0]    addr_q, addr_d;
  logic [1:0]    req, arb_grant;
  logic          rd, wr, drive;

  assign req = {i_tx_valid & i_usb_flagd, i_usb_flaga};

  usb_rr_arbiter u_arb (
    .clk_i     (i_usb_ifclk),
    .rst_ni    (i_rst_n),
    .req_i     (req),
    .advance_i (state_q == ST_IDLE),
    .grant_o   (arb_grant)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idle_d      = idle_q;
    turn_d      = turn_q;
    addr_d      = addr_q;
    rd          = 1'b0;
    wr          = 1'b0;
    drive       = 1'b0;
    o_usb_slrd  = STROBE_OFF;
    o_usb_slwr  = STROBE_OFF;
    o_usb_sloe  = STROBE_OFF;
    o_usb_pkend = STROBE_OFF;
    o_rx_valid  = 1'b0;
    o_tx_ready  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (arb_grant == GNT_RX) begin
          state_d = ST_RX_SETUP;
          addr_d  = EP_OUT_ADDR;
        end else if (arb_grant == GNT_TX) begin
          state_d = ST_TX_SETUP;
          addr_d  = EP_IN_ADDR;
        end
      end
      ST_RX_SETUP: begin
        o_usb_sloe = STROBE_ON;
        state_d    = ST_RX_BURST;
      end
      ST_RX_BURST: begin
        o_usb_sloe = STROBE_ON;
        rd         = i_usb_flaga & i_rx_ready & (cnt_q < CNT_MAX);
        o_usb_slrd = rd ? STROBE_ON : STROBE_OFF;
        o_rx_valid = rd;
        if (rd) cnt_d = cnt_q + CW'(1);
        if (!i_usb_flaga || (rd && (cnt_q == CNT_LAST))) begin
          state_d = ST_TURN;
          turn_d  = '0;
        end
      end
      ST_TX_SETUP: begin
        drive   = 1'b1;
        idle_d  = '0;
        state_d = ST_TX_BURST;
      end
      ST_TX_BURST: begin
        drive      = 1'b1;
        o_tx_ready = i_usb_flagd & (cnt_q < CNT_MAX);
        wr         = i_tx_valid & o_tx_ready;
        o_usb_slwr = wr ? STROBE_ON : STROBE_OFF;
        if (wr) cnt_d = cnt_q + CW'(1);
        // A stalled-but-valid source is not idle; only missing data counts.
        idle_d = i_tx_valid ? '0 : idle_q + IW'(1);
        if (wr && i_tx_last) begin
          state_d = ST_TX_PKEND;
        end else if ((wr && (cnt_q == CNT_LAST)) ||
                     (!i_tx_valid && (idle_q == IDLE_LAST))) begin
          state_d = ST_TURN;
          turn_d  = '0;
        end
      end
      ST_TX_PKEND: begin
        drive       = 1'b1;
        o_usb_pkend = STROBE_ON;
        state_d     = ST_TURN;
        turn_d      = '0;
      end
      ST_TURN: begin
        if (turn_q == TURN_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          idle_d  = '0;
        end else begin
          turn_d = turn_q + 3'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Pins go safe the moment reset is seen, before the state register follows.
    if (!i_rst_n) begin
      drive       = 1'b0;
      o_usb_slrd  = STROBE_OFF;
      o_usb_slwr  = STROBE_OFF;
      o_usb_sloe  = STROBE_OFF;
      o_usb_pkend = STROBE_OFF;
      o_rx_valid  = 1'b0;
      o_tx_ready  = 1'b0;
    end
  end

  always_ff @(posedge i_usb_ifclk) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idle_q  <= '0;
      turn_q  <= '0;
      addr_q  <= EP_OUT_ADDR;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idle_q  <= idle_d;
      turn_q  <= turn_d;
      addr_q  <= addr_d;
    end
  end

  assign io_usb_data = drive ? i_tx_data : {DATA_WIDTH{1'bz}};
  assign o_rx_data   = io_usb_data;
  assign o_usb_addr  = i_rst_n ? addr_q : EP_OUT_ADDR;
  assign o_grant     = i_rst_n ? grant_of(state_q) : GNT_NONE;
  assign o_busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_usb_fifo_arbiter.sv
// Directed bench with an FX2 endpoint model and RX/TX scoreboards, plus a second
// instance with MAX_BURST=4 for the contention sequence.
module tb_usb_fifo_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance (default parameters)
  logic        rst_n, flaga, flagd, rx_ready, tx_valid, tx_last;
  logic [15:0] tx_data;
  wire  [15:0] usb_data;
  wire  [15:0] rx_data;
  wire  [1:0]  addr, grant;
  wire         slrd, slwr, sloe, pkend, rx_valid, tx_ready, busy;
  logic [15:0] fx2_word;
  logic        probe_en;
  logic [15:0] probe_val;

  assign usb_data = probe_en ? probe_val :
                    ((!sloe && addr == 2'b00) ? fx2_word : 16'hzzzz);

  usb_fifo_arbiter dut (
    .i_usb_ifclk(clk), .i_rst_n(rst_n), .i_usb_flaga(flaga), .i_usb_flagd(flagd),
    .io_usb_data(usb_data), .o_usb_addr(addr), .o_usb_slrd(slrd), .o_usb_slwr(slwr),
    .o_usb_sloe(sloe), .o_usb_pkend(pkend), .o_rx_data(rx_data), .o_rx_valid(rx_valid),
    .i_rx_ready(rx_ready), .i_tx_data(tx_data), .i_tx_valid(tx_valid), .i_tx_last(tx_last),
    .o_tx_ready(tx_ready), .o_grant(grant), .o_busy(busy)
  );

  // Contention instance (MAX_BURST=4), both sides always requesting
  logic        c_rst_n, c_flaga, c_flagd, c_rx_ready, c_tx_valid, c_tx_last;
  logic [15:0] c_tx_data;
  wire  [15:0] c_bus;
  wire  [15:0] c_rx_data;
  wire  [1:0]  c_addr, c_grant;
  wire         c_slrd, c_slwr, c_sloe, c_pkend, c_rx_valid, c_tx_ready, c_busy;

  assign c_bus = (!c_sloe) ? 16'hB000 : 16'hzzzz;

  usb_fifo_arbiter #(.MAX_BURST(4)) dut4 (
    .i_usb_ifclk(clk), .i_rst_n(c_rst_n), .i_usb_flaga(c_flaga), .i_usb_flagd(c_flagd),
    .io_usb_data(c_bus), .o_usb_addr(c_addr), .o_usb_slrd(c_slrd), .o_usb_slwr(c_slwr),
    .o_usb_sloe(c_sloe), .o_usb_pkend(c_pkend), .o_rx_data(c_rx_data), .o_rx_valid(c_rx_valid),
    .i_rx_ready(c_rx_ready), .i_tx_data(c_tx_data), .i_tx_valid(c_tx_valid), .i_tx_last(c_tx_last),
    .o_tx_ready(c_tx_ready), .o_grant(c_grant), .o_busy(c_busy)
  );

  int checks = 0;
  int errors = 0;

  logic [15:0] ep2_q[$];
  logic [15:0] rx_exp[$];
  logic [15:0] tx_exp[$];
  logic [16:0] tx_src[$];
  logic [1:0]  c_exp[$];

  int   n_rd, n_wr, n_pk, n_turn;
  int   c_words, c_done, idle_cyc, g;
  logic [1:0]  c_prev;
  logic        c_active, do_rd, do_tx;
  logic [15:0] dummy16;
  logic [16:0] dummy17, head;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void drive();
    flaga    = (ep2_q.size() != 0);
    fx2_word = flaga ? ep2_q[0] : 16'h0;
    tx_valid = (tx_src.size() != 0);
    head     = tx_valid ? tx_src[0] : 17'h0;
    tx_data  = head[15:0];
    tx_last  = head[16];
  endfunction

  function automatic void clr_counts();
    n_rd = 0; n_wr = 0; n_pk = 0; n_turn = 0;
  endfunction

  task automatic sample();
    @(negedge clk);
    if (rx_valid) begin
      if (rx_exp.size() == 0) chk("rx_unexpected", 32'd1, 32'd0);
      else                    chk("rx_word", 32'(rx_data), 32'(rx_exp.pop_front()));
    end
    if (!slwr) begin
      if (tx_exp.size() == 0) chk("tx_unexpected", 32'd1, 32'd0);
      else                    chk("tx_word", 32'(usb_data), 32'(tx_exp.pop_front()));
    end
    if (!pkend) begin
      chk("pkend_slwr", 32'(slwr), 32'd1);
      chk("pkend_after_last", tx_exp.size(), 32'd0);
      n_pk++;
    end
    if (!sloe) chk("sloe_owner", 32'(grant), 32'd1);
    if (!slrd) n_rd++;
    if (!slwr) n_wr++;
    if (busy && grant == 2'b00) n_turn++;
    do_rd = !slrd;
    do_tx = tx_valid && tx_ready;
    if (c_active) begin
      if (c_grant != 2'b00 && c_prev == 2'b00) begin
        if (c_exp.size() == 0) chk("c_grant_extra", 32'd1, 32'd0);
        else                   chk("c_grant_side", 32'(c_grant), 32'(c_exp.pop_front()));
        c_words = 0;
      end
      if (!c_slrd || !c_slwr) c_words++;
      if (c_grant == 2'b00 && c_prev != 2'b00) begin
        chk("c_words_per_grant", c_words, 32'd4);
        c_done++;
      end
      c_prev = c_grant;
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    if (do_rd && ep2_q.size() != 0) dummy16 = ep2_q.pop_front();
    if (do_tx && tx_src.size() != 0) dummy17 = tx_src.pop_front();
    drive();
  endtask

  task automatic step();
    sample();
    advance();
  endtask

  task automatic run_to_idle(input string tag, input int bound);
    int k;
    k = 0;
    step();
    while (busy && k < bound) begin
      step();
      k++;
    end
    if (k >= bound) chk(tag, 32'd0, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; flagd = 1'b1; rx_ready = 1'b1; probe_en = 1'b1; probe_val = 16'h5A5A;
    c_rst_n = 1'b0; c_flaga = 1'b1; c_flagd = 1'b1; c_rx_ready = 1'b1;
    c_tx_valid = 1'b1; c_tx_last = 1'b0; c_tx_data = 16'hC000;
    c_active = 1'b0; c_prev = 2'b00; c_words = 0; c_done = 0;
    do_rd = 1'b0; do_tx = 1'b0;
    clr_counts();
    drive();

    // Reset state
    advance();
    advance();
    sample();
    chk("rst_strobes", 32'({slrd, slwr, sloe, pkend}), 32'hF);
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_tx_ready", 32'(tx_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_bus_z", 32'(usb_data), 32'h5A5A);
    advance();
    rst_n = 1'b1; probe_en = 1'b0;

    // 1: reset in the middle of a TX burst
    clr_counts();
    for (int i = 0; i < 8; i++) begin
      tx_src.push_back({1'b0, 16'hA100 + 16'(i)});
      tx_exp.push_back(16'hA100 + 16'(i));
    end
    drive();
    g = 0;
    while (n_wr < 5 && g < 30) begin step(); g++; end
    if (g >= 30) chk("t1_timeout", 32'd0, 32'd1);
    rst_n = 1'b0; probe_en = 1'b1;
    sample();
    chk("t1_slwr_forced", 32'(slwr), 32'd1);
    chk("t1_bus_z", 32'(usb_data), 32'h5A5A);
    chk("t1_tx_ready", 32'(tx_ready), 32'd0);
    chk("t1_grant", 32'(grant), 32'd0);
    tx_src.delete();
    tx_exp.delete();
    advance();
    sample();
    chk("t1_state_idle", 32'(busy), 32'd0);
    chk("t1_grant_after", 32'(grant), 32'd0);
    advance();
    rst_n = 1'b1; probe_en = 1'b0;
    repeat (3) step();
    chk("t1_stay_idle", 32'(busy), 32'd0);
    chk("t1_no_pkend", n_pk, 32'd0);

    // 2: RX only, 10 words
    clr_counts();
    for (int i = 0; i < 10; i++) begin
      ep2_q.push_back(16'h1000 + 16'(i));
      rx_exp.push_back(16'h1000 + 16'(i));
    end
    drive();
    sample();
    chk("t2_idle_arb", 32'(busy), 32'd0);
    advance();
    sample();
    chk("t2_rx_setup", 32'({grant, sloe, slrd}), 32'b0101);
    chk("t2_setup_addr", 32'(addr), 32'd0);
    advance();
    run_to_idle("t2_timeout", 40);
    chk("t2_reads", n_rd, 32'd10);
    chk("t2_turn", n_turn, 32'd2);
    chk("t2_rx_drained", rx_exp.size(), 32'd0);

    // 3: TX packet of 4 words with PKEND
    clr_counts();
    for (int i = 1; i <= 4; i++) begin
      tx_src.push_back({(i == 4), 16'hA000 + 16'(i)});
      tx_exp.push_back(16'hA000 + 16'(i));
    end
    drive();
    run_to_idle("t3_timeout", 40);
    chk("t3_writes", n_wr, 32'd4);
    chk("t3_pkend", n_pk, 32'd1);
    chk("t3_turn", n_turn, 32'd2);
    chk("t3_tx_drained", tx_exp.size(), 32'd0);

    // 5: TX stall on flagd, then idle timeout
    clr_counts();
    for (int i = 0; i < 8; i++) begin
      tx_src.push_back({1'b0, 16'hB100 + 16'(i)});
      tx_exp.push_back(16'hB100 + 16'(i));
    end
    drive();
    g = 0;
    while (n_wr < 3 && g < 20) begin step(); g++; end
    if (g >= 20) chk("t5_timeout_a", 32'd0, 32'd1);
    flagd = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sample();
      chk("t5_stall_ready", 32'(tx_ready), 32'd0);
      chk("t5_stall_slwr", 32'(slwr), 32'd1);
      chk("t5_stall_grant", 32'(grant), 32'd2);
      advance();
    end
    flagd = 1'b1;
    g = 0;
    while (n_wr < 8 && g < 20) begin step(); g++; end
    if (g >= 20) chk("t5_timeout_b", 32'd0, 32'd1);
    idle_cyc = 0;
    g = 0;
    while (grant == 2'b10 && g < 40) begin step(); idle_cyc++; g++; end
    chk("t5_idle_cycles", idle_cyc, 32'd16);
    run_to_idle("t5_timeout_c", 10);
    chk("t5_no_pkend", n_pk, 32'd0);
    chk("t5_turn", n_turn, 32'd2);
    chk("t5_tx_drained", tx_exp.size(), 32'd0);

    // 6: RX sink stall
    clr_counts();
    for (int i = 0; i < 12; i++) begin
      ep2_q.push_back(16'h6000 + 16'(i));
      rx_exp.push_back(16'h6000 + 16'(i));
    end
    drive();
    g = 0;
    while (n_rd < 4 && g < 20) begin step(); g++; end
    if (g >= 20) chk("t6_timeout_a", 32'd0, 32'd1);
    rx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sample();
      chk("t6_stall_slrd", 32'(slrd), 32'd1);
      chk("t6_stall_valid", 32'(rx_valid), 32'd0);
      chk("t6_stall_grant", 32'(grant), 32'd1);
      advance();
    end
    rx_ready = 1'b1;
    run_to_idle("t6_timeout_b", 40);
    chk("t6_reads", n_rd, 32'd12);
    chk("t6_rx_drained", rx_exp.size(), 32'd0);
    chk("t6_ep2_empty", ep2_q.size(), 32'd0);

    // 4: contention with MAX_BURST=4
    for (int i = 0; i < 3; i++) begin
      c_exp.push_back(2'b01);
      c_exp.push_back(2'b10);
    end
    c_active = 1'b1;
    c_rst_n = 1'b1;
    g = 0;
    while (c_done < 6 && g < 120) begin step(); g++; end
    chk("c_grants_done", c_done, 32'd6);
    chk("c_no_pkend_total", 32'(c_pkend), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/usb_fifo_arbiter.md
Name: usb_fifo_arbiter

Overview:
- Owns the FX2 synchronous slave-FIFO pins and time-shares them between two requesters.
  - RX stream: EP2 OUT to FPGA.
  - TX stream: FPGA to EP6 IN.
- Round-robin arbitration, bounded bursts, bus turnaround, and TX packet commit via PKEND.
- Sits between the FX2 pins and the FPGA-side datapath; replaces ad-hoc direction sequencing in the USB bridge.

Parameters:
- DATA_WIDTH, 16: FX2 data bus width.
- MAX_BURST, 256: max words transferred per grant before re-arbitration.
- TURNAROUND, 2: idle cycles with the bus released between grants (range 1..7).
- TX_IDLE_TIMEOUT, 16: consecutive TX-granted cycles with i_tx_valid=0 before the grant is released.
- EP_OUT_ADDR, 2'b00: FIFOADR value for EP2.
- EP_IN_ADDR, 2'b10: FIFOADR value for EP6.

Ports:
- i_usb_ifclk  in  1  interface clock; all logic is on its rising edge.
- i_rst_n  in  1  reset, synchronous, active-low.
- i_usb_flaga  in  1  EP2 not-empty (1 = data available).
- i_usb_flagd  in  1  EP6 not-full (1 = space available).
- io_usb_data  inout  DATA_WIDTH  FX2 data bus.
- o_usb_addr  out  2  FIFOADR.
- o_usb_slrd  out  1  read strobe, active-low.
- o_usb_slwr  out  1  write strobe, active-low.
- o_usb_sloe  out  1  output enable, active-low.
- o_usb_pkend  out  1  packet end, active-low.
- o_rx_data  out  DATA_WIDTH  word read from EP2.
- o_rx_valid  out  1  o_rx_data valid; each cycle with o_rx_valid=1 transfers one word.
- i_rx_ready  in  1  RX sink can accept.
- i_tx_data  in  DATA_WIDTH  word for EP6.
- i_tx_valid  in  1  TX word present.
- i_tx_last  in  1  word is last of packet; commit with PKEND.
- o_tx_ready  out  1  TX word accepted when i_tx_valid is also 1.
- o_grant  out  2  01 = RX, 10 = TX, 00 = none.
- o_busy  out  1  state != IDLE.

Behaviour:
- Reset (i_rst_n=0 at an edge):
  - state to IDLE, burst/idle counters to 0, last_grant to TX (RX wins the first tie).
  - While i_rst_n=0, all strobes are forced high combinationally, o_usb_addr=EP_OUT_ADDR, bus Z, o_rx_valid=0, o_tx_ready=0, o_grant=00.
  - Reset mid-burst aborts the burst with no PKEND.
- States:
  - IDLE
  - RX_SETUP: 1 cycle; addr=EP_OUT_ADDR, sloe=0.
  - RX_BURST
  - TX_SETUP: 1 cycle; addr=EP_IN_ADDR, bus driven.
  - TX_BURST
  - TX_PKEND: 1 cycle.
  - TURN: TURNAROUND cycles.
- Arbitration in IDLE:
  - req_rx = flaga; req_tx = i_tx_valid & flagd.
  - Only one request: grant it.
  - Both requests: grant the side opposite last_grant.
  - RX grant goes to RX_SETUP; TX grant goes to TX_SETUP.
  - last_grant updates on grant.
- RX_BURST:
  - rd = flaga & i_rx_ready & (cnt < MAX_BURST); rd is combinational.
  - o_usb_slrd = ~rd; o_rx_valid = rd; o_rx_data = io_usb_data; sloe=0.
  - cnt increments on rd.
  - Exit to TURN when flaga=0, or when a rd occurs with cnt == MAX_BURST-1.
  - i_rx_ready=0 stalls the burst; it does not exit.
- TX_BURST:
  - o_tx_ready = flagd & (cnt < MAX_BURST); wr = i_tx_valid & o_tx_ready.
  - o_usb_slwr = ~wr; io_usb_data = i_tx_data.
  - cnt increments on wr.
  - wr & i_tx_last: go to TX_PKEND (pkend=0, slwr=1, bus still driven), then TURN.
  - cnt reaches MAX_BURST without last: go to TURN, no PKEND. The next TX grant continues the same packet.
  - flagd=0: ready drops and the burst stalls; FX2 auto-commits the full packet.
  - i_tx_valid=0 for TX_IDLE_TIMEOUT consecutive cycles: go to TURN, no PKEND.
  - Any wr clears the idle counter.
- TURN:
  - All strobes high, sloe=1, bus Z, addr held.
  - Lasts exactly TURNAROUND cycles, then IDLE; cnt cleared.
- Bus ownership:
  - io_usb_data is driven only in TX_SETUP, TX_BURST and TX_PKEND.
  - sloe=0 only in RX_SETUP and RX_BURST.
  - sloe=0 and the FPGA bus driver are never active in the same cycle.
- o_grant is decoded from state: RX for RX_*, TX for TX_*, 00 for IDLE and TURN.
- Counter width: $clog2(MAX_BURST+1); must not wrap.

Decomposition:
- Shared package usb_pkg:
  - state encoding localparams.
  - EP address constants.
  - strobe-active level constant (1'b0).
  - grant encodings.
- One sub-module: usb_rr_arbiter. 2-requester round-robin holding last_grant, with inputs req[1:0] and advance, and output grant one-hot.

Test Plan:
1. Reset mid-TX: TX_BURST with cnt=5, drive i_rst_n=0 for 1 cycle. Required: same cycle slwr=1 and bus Z; next cycle state IDLE, o_grant=00, pkend never asserted.
2. RX only: flaga=1 for 10 words, then 0; i_rx_ready=1. Required: RX_SETUP, 10 cycles slrd=0 / o_rx_valid=1, then TURN 2 cycles, then IDLE. Sink receives 10 words in order.
3. TX packet: 4 words 0xA001..0xA004, last on the 4th, flagd=1. Required: 4 slwr=0 cycles with matching data, then 1 cycle pkend=0, then TURN.
4. Contention: flaga=1 and tx_valid=1 constantly, MAX_BURST=4. Required: grants alternate RX, TX, RX, TX; 4 words per grant; never two consecutive grants to the same side.
5. TX backpressure and timeout: flagd=0 for 8 cycles mid-burst, then tx_valid=0 for 16 cycles. Required: o_tx_ready=0 and slwr=1 during the stall; exit to TURN after exactly 16 idle cycles, with no PKEND.
6. RX stall: i_rx_ready=0 for 5 cycles mid-burst. Required: slrd=1, stays in RX_BURST, no word loss; resumes when ready returns.
